// File: rtl/oam_dma_pkg.sv
// Shared types and constants for the OAM DMA controller.
package oam_dma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        RUN
    } dma_state_t;

    localparam int          OAM_LEN_C      = 160;
    localparam logic [15:0] DMA_REG_ADDR_C = 16'hFF46;
    localparam logic [2:0]  VRAM_PAGE_HI   = 3'b100;

endpackage

// File: rtl/oam_dma_idx.sv
// Byte index counter for the OAM DMA: clears on start, steps per written byte,
// and holds at the last index instead of running past the transfer length.
module oam_dma_idx
    import oam_dma_pkg::*;
#(
    parameter int LEN = OAM_LEN_C
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [7:0] idx,
    output logic       term
);

    assign term = (idx == 8'(LEN - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (en && !term) begin
            idx <= idx + 8'd1;
        end
    end

endmodule

// File: rtl/oam_dma.sv
// OAM DMA controller: FF46 source register, IDLE/PEND/RUN sequencer and DMA address mux.
// Optional OAM_DMA_SRC_MIRROR_EN folds source pages E0-FF onto C0-DF.
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter int          OAM_LEN      = OAM_LEN_C,
    parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mcyc,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic [15:0] a,
    input  logic [7:0]  d,
    output logic [7:0]  dout,
    output logic        dout_en,
    output logic        dma_run,
    output logic [15:0] dma_a,
    output logic        vram_to_oam,
    output logic        oam_addr_ndma,
    output logic        oam_wr
);

    dma_state_t state;
    logic [7:0] src_reg;
    logic [7:0] src_act;
    logic [7:0] idx;
    logic [7:0] page;
    logic       req;
    logic       reg_wr;
    logic       term;
    logic       step;
    logic       start;

    assign reg_wr = cpu_wr && (a == DMA_REG_ADDR);
    // A pending request wins over the byte write on the same boundary (restart).
    assign step   = mcyc && (state == RUN) && !req;
    assign start  = mcyc && (state == PEND) && !req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            src_reg <= '0;
            src_act <= '0;
            req     <= 1'b0;
            dma_run <= 1'b0;
        end else begin
            if (mcyc) begin
                case (state)
                    IDLE: begin
                        if (req) begin
                            state   <= PEND;
                            src_act <= src_reg;
                            req     <= 1'b0;
                        end
                    end
                    PEND: begin
                        if (req) begin
                            src_act <= src_reg;
                            req     <= 1'b0;
                        end else begin
                            state   <= RUN;
                            dma_run <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (req) begin
                            state   <= PEND;
                            src_act <= src_reg;
                            req     <= 1'b0;
                        end else if (term) begin
                            state   <= IDLE;
                            dma_run <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            // Written after the FSM so a write on an mcyc edge re-arms req.
            if (reg_wr) begin
                src_reg <= d;
                req     <= 1'b1;
            end
        end
    end

    oam_dma_idx #(.LEN(OAM_LEN)) u_idx (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .en    (step),
        .idx   (idx),
        .term  (term)
    );

    always_comb begin
        page = src_act;
`ifdef OAM_DMA_SRC_MIRROR_EN
        if (src_act >= 8'hE0) begin
            page = src_act - 8'h20;
        end
`endif
    end

    assign dma_a         = {page, idx};
    assign vram_to_oam   = (src_act[7:5] == VRAM_PAGE_HI);
    assign oam_addr_ndma = !dma_run;
    assign oam_wr        = step && !reset;
    assign dout          = src_reg;
    assign dout_en       = cpu_rd && (a == DMA_REG_ADDR);

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma using a boundary-timeline reference model.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        mcyc;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  dout;
    logic        dout_en;
    logic        dma_run;
    logic [15:0] dma_a;
    logic        vram_to_oam;
    logic        oam_addr_ndma;
    logic        oam_wr;

    int checks   = 0;
    int failures = 0;

    // Reference model: transfer timeline keyed on M-cycle boundary numbers.
    bit         pend_valid = 0;
    logic [7:0] pend_val   = '0;
    logic [7:0] src_m      = '0;
    logic [7:0] reg_m      = '0;
    bit         xfer       = 0;
    bit         carry      = 0;
    int         tc         = 0;
    int         b          = 0;
    int         wr_count   = 0;

    always #5 clk = ~clk;

    oam_dma dut (
        .clk           (clk),
        .reset         (reset),
        .mcyc          (mcyc),
        .cpu_wr        (cpu_wr),
        .cpu_rd        (cpu_rd),
        .a             (a),
        .d             (d),
        .dout          (dout),
        .dout_en       (dout_en),
        .dma_run       (dma_run),
        .dma_a         (dma_a),
        .vram_to_oam   (vram_to_oam),
        .oam_addr_ndma (oam_addr_ndma),
        .oam_wr        (oam_wr)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] page_of(input logic [7:0] s);
`ifdef OAM_DMA_SRC_MIRROR_EN
        return (s >= 8'hE0) ? s - 8'h20 : s;
`else
        return s;
`endif
    endfunction

    // Sampled just before boundary b; then the model consumes any pending write.
    task automatic boundary_check();
        bit consume;
        bit run_e;
        bit wr_e;
        int k;
        consume = pend_valid;
        k       = b - (tc + 2);
        run_e   = xfer && ((b >= tc + 2 && b <= tc + 161) || (b == tc + 1 && carry));
        wr_e    = xfer && !consume && k >= 0 && k < 160;
        chk("dma_run", 16'(dma_run), 16'(run_e));
        chk("oam_addr_ndma", 16'(oam_addr_ndma), 16'(!run_e));
        chk("oam_wr", 16'(oam_wr), 16'(wr_e));
        if (wr_e) chk("dma_a", dma_a, {page_of(src_m), 8'(k)});
        if (run_e) chk("vram_to_oam", 16'(vram_to_oam), 16'(src_m[7:5] == 3'b100));
        chk("dout", 16'(dout), 16'(reg_m));
        chk("dout_en", 16'(dout_en), 16'(cpu_rd && (a == 16'hFF46)));
        if (oam_wr) wr_count++;
        if (consume) begin
            carry      = run_e;
            tc         = b;
            src_m      = pend_val;
            pend_valid = 0;
            xfer       = 1;
        end
        b++;
    endtask

    task automatic mcycle(input bit wr, input logic [7:0] v, input bit at_edge);
        for (int c = 0; c < 4; c++) begin
            mcyc   = (c == 3);
            cpu_rd = 1'($urandom_range(0, 1));
            a      = ($urandom_range(0, 1) == 1) ? 16'hFF46 : 16'($urandom);
            d      = 8'($urandom);
            cpu_wr = wr && (at_edge ? (c == 3) : (c == 1));
            if (cpu_wr) begin
                a = 16'hFF46;
                d = v;
            end
            if (cpu_wr && !at_edge) begin
                pend_valid = 1;
                pend_val   = v;
                reg_m      = v;
            end
            @(negedge clk);
            if (c == 3) begin
                boundary_check();
                if (cpu_wr) begin
                    pend_valid = 1;
                    pend_val   = v;
                    reg_m      = v;
                end
            end
            @(posedge clk);
            #1;
        end
        mcyc   = 1'b0;
        cpu_wr = 1'b0;
    endtask

    task automatic idle_run(input int n);
        for (int i = 0; i < n; i++) mcycle(0, 8'h00, 0);
    endtask

    initial begin
        logic [7:0] v;
        int         n;

        reset  = 1'b1;
        mcyc   = 1'b0;
        cpu_wr = 1'b0;
        cpu_rd = 1'b0;
        a      = '0;
        d      = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_dma_run", 16'(dma_run), 16'h0);
        chk("rst_ndma", 16'(oam_addr_ndma), 16'h1);
        chk("rst_oam_wr", 16'(oam_wr), 16'h0);
        chk("rst_dma_a", dma_a, 16'h0000);
        chk("rst_vram", 16'(vram_to_oam), 16'h0);
        chk("rst_dout", 16'(dout), 16'h0);
        chk("rst_dout_en", 16'(dout_en), 16'h0);
        reset = 1'b0;

        // Plain WRAM transfer.
        wr_count = 0;
        mcycle(1, 8'hC1, 0);
        idle_run(170);
        chk("count_c1", 16'(wr_count), 16'd160);

        // VRAM source page.
        mcycle(1, 8'h80, 0);
        idle_run(170);

        // Restart at byte 50 with a new source.
        wr_count = 0;
        mcycle(1, 8'hC0, 0);
        idle_run(51);
        mcycle(1, 8'hD0, 0);
        idle_run(170);
        chk("count_restart", 16'(wr_count), 16'd210);

        // Echo-range source page.
        mcycle(1, 8'hFE, 0);
        idle_run(170);

        // Write landing on the mcyc edge itself.
        mcycle(1, 8'($urandom), 1);
        idle_run(170);

        // Random sources with a random second write (PEND, RUN or after IDLE).
        for (int it = 0; it < 3; it++) begin
            v = 8'($urandom);
            mcycle(1, v, 0);
            n = $urandom_range(0, 170);
            idle_run(n);
            mcycle(1, 8'($urandom), 0);
            idle_run(170);
        end

        // Reset mid-transfer at idx 80.
        mcycle(1, 8'hC5, 0);
        idle_run(81);
        reset  = 1'b1;
        cpu_rd = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_dma_run", 16'(dma_run), 16'h0);
        chk("mid_rst_ndma", 16'(oam_addr_ndma), 16'h1);
        chk("mid_rst_dout", 16'(dout), 16'h0);
        chk("mid_rst_dma_a", dma_a, 16'h0000);
        chk("mid_rst_oam_wr", 16'(oam_wr), 16'h0);
        reset      = 1'b0;
        xfer       = 0;
        pend_valid = 0;
        carry      = 0;
        reg_m      = '0;
        src_m      = '0;
        wr_count   = 0;
        idle_run(10);
        chk("post_rst_count", 16'(wr_count), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
